// File: rtl/parking_gate_arbiter.sv
// Shares the lot's single barrier between entry and exit lanes; entry is refused when full.
// Grants appear 1 cycle after a request is seen in IDLE. The gate closes when the passage completes or times out.
module parking_gate_arbiter #(
    parameter int CAPACITY     = 10,
    parameter int OPEN_TIMEOUT = 50,
    parameter int CLOSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [3:0] count,
    input  logic       enter_done,
    input  logic       exit_done,
    output logic       gate_open,
    output logic       grant_in,
    output logic       grant_out,
    output logic       full,
    output logic       timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GIN   = 2'd1;
    localparam logic [1:0] S_GOUT  = 2'd2;
    localparam logic [1:0] S_CLOSE = 2'd3;

    localparam logic [3:0] CAP4     = 4'(CAPACITY);
    localparam logic [7:0] TMO_LAST = 8'(OPEN_TIMEOUT - 1);
    localparam logic [7:0] CLS_LAST = 8'(CLOSE_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       last_out_q, last_out_d;
    logic       tmo_d;
    logic       gate_open_q, grant_in_q, grant_out_q, full_q, timeout_err_q;
    logic       elig_in, elig_out;

    assign elig_in  = entry_req && (count < CAP4);
    assign elig_out = exit_req && (count != 4'd0);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        last_out_d = last_out_q;
        tmo_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = 8'd0;
                // On contention the lane that did not own the last grant wins.
                if (elig_in && (!elig_out || last_out_q)) begin
                    state_d    = S_GIN;
                    last_out_d = 1'b0;
                end else if (elig_out) begin
                    state_d    = S_GOUT;
                    last_out_d = 1'b1;
                end
            end
            S_GIN: begin
                if (enter_done) begin
                    state_d = S_CLOSE;
                    timer_d = 8'd0;
                end else if (timer_q == TMO_LAST) begin
                    state_d = S_CLOSE;
                    timer_d = 8'd0;
                    tmo_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_GOUT: begin
                if (exit_done) begin
                    state_d = S_CLOSE;
                    timer_d = 8'd0;
                end else if (timer_q == TMO_LAST) begin
                    state_d = S_CLOSE;
                    timer_d = 8'd0;
                    tmo_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                if (timer_q == CLS_LAST) begin
                    state_d = S_IDLE;
                    timer_d = 8'd0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            timer_q       <= 8'd0;
            last_out_q    <= 1'b1;
            gate_open_q   <= 1'b0;
            grant_in_q    <= 1'b0;
            grant_out_q   <= 1'b0;
            full_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            last_out_q    <= last_out_d;
            gate_open_q   <= (state_d == S_GIN) || (state_d == S_GOUT);
            grant_in_q    <= (state_d == S_GIN);
            grant_out_q   <= (state_d == S_GOUT);
            full_q        <= (count >= CAP4);
            timeout_err_q <= tmo_d;
        end
    end

    assign gate_open   = gate_open_q;
    assign grant_in    = grant_in_q;
    assign grant_out   = grant_out_q;
    assign full        = full_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench: stimulus queues the hand-computed output after each edge; a monitor compares at negedge.
`timescale 1ns/100ps
module tb_parking_gate_arbiter;

    // Expected vector layout: {gate_open, grant_in, grant_out, full, timeout_err}
    localparam logic [4:0] E_IDLE = 5'b00000;
    localparam logic [4:0] E_GIN  = 5'b11000;
    localparam logic [4:0] E_GOUT = 5'b10100;
    localparam logic [4:0] E_FULL = 5'b00010;
    localparam logic [4:0] E_TERR = 5'b00001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entry_req = 1'b0, exit_req = 1'b0;
    logic [3:0] count = 4'd0;
    logic       enter_done = 1'b0, exit_done = 1'b0;
    logic       gate_open, grant_in, grant_out, full, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    parking_gate_arbiter #(.CAPACITY(10), .OPEN_TIMEOUT(20), .CLOSE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
        .count(count), .enter_done(enter_done), .exit_done(exit_done),
        .gate_open(gate_open), .grant_in(grant_in), .grant_out(grant_out),
        .full(full), .timeout_err(timeout_err)
    );

    function automatic logic [4:0] outs();
        return {gate_open, grant_in, grant_out, full, timeout_err};
    endfunction

    // Monitor: one expected vector is consumed per clock once stimulus has issued it.
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (outs() !== e || (grant_in && grant_out)) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t actual=%b required=%b", $time, outs(), e);
                end
            end
        end
    end

    task automatic step(input int n, input logic er, input logic xr, input logic [3:0] c,
                        input logic ed, input logic xd, input logic [4:0] e);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            entry_req  = er;
            exit_req   = xr;
            count      = c;
            enter_done = ed;
            exit_done  = xd;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_now(input string name, input logic [4:0] e);
        n_checks++;
        if (outs() !== e) begin
            n_fail++;
            $display("FAIL %s actual=%b required=%b", name, outs(), e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random inputs
        for (int i = 0; i < 6; i++)
            step(1, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), E_IDLE);
        @(negedge clk);
        #1;
        check_now("reset_hold", E_IDLE);
        {entry_req, exit_req, enter_done, exit_done} = 4'b0;
        count = 4'd0;
        reset = 1'b1;
        step(3, 0, 0, 4'd0, 0, 0, E_IDLE);

        // Single entry grant, done pulse, close spacing
        step(1, 1, 0, 4'd3, 0, 0, E_GIN);
        step(5, 1, 0, 4'd3, 0, 0, E_GIN);
        step(1, 1, 0, 4'd3, 1, 0, E_IDLE);
        step(4, 1, 0, 4'd3, 0, 0, E_IDLE);
        step(1, 1, 0, 4'd3, 0, 0, E_GIN);
        step(1, 0, 0, 4'd4, 1, 0, E_IDLE);
        step(6, 0, 0, 4'd4, 0, 0, E_IDLE);

        // Lot full: entry refused, exit still served
        step(3, 1, 0, 4'd10, 0, 0, E_FULL);
        step(4, 1, 1, 4'd10, 0, 0, E_GOUT | E_FULL);
        step(1, 1, 0, 4'd9, 0, 1, E_IDLE);
        step(5, 0, 0, 4'd9, 0, 0, E_IDLE);

        // Contention right after reset: entry first, then exit
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_now("reset_pulse", E_IDLE);
        reset = 1'b1;
        step(1, 1, 1, 4'd5, 0, 0, E_GIN);
        step(2, 1, 1, 4'd5, 0, 0, E_GIN);
        step(1, 1, 1, 4'd5, 0, 1, E_GIN);
        step(1, 1, 1, 4'd5, 0, 0, E_GIN);
        step(1, 1, 1, 4'd5, 1, 0, E_IDLE);
        step(4, 1, 1, 4'd5, 0, 0, E_IDLE);
        step(1, 1, 1, 4'd5, 0, 0, E_GOUT);
        step(1, 0, 0, 4'd5, 0, 1, E_IDLE);
        step(5, 0, 0, 4'd5, 0, 0, E_IDLE);

        // Timeout after exactly 20 open cycles
        step(20, 1, 0, 4'd3, 0, 0, E_GIN);
        step(1, 1, 0, 4'd3, 0, 0, E_TERR);
        step(4, 1, 0, 4'd3, 0, 0, E_IDLE);
        // Done on the 20th cycle wins over the timeout
        step(20, 1, 0, 4'd3, 0, 0, E_GIN);
        step(1, 1, 0, 4'd3, 1, 0, E_IDLE);
        step(6, 0, 0, 4'd3, 0, 0, E_IDLE);

        // Asynchronous reset during an exit grant
        step(1, 0, 1, 4'd2, 0, 0, E_GOUT);
        step(2, 0, 1, 4'd2, 0, 0, E_GOUT);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_now("async_reset", E_IDLE);
        entry_req = 1'b1;
        exit_req  = 1'b0;
        count     = 4'd2;
        #1;
        reset = 1'b1;
        exp_q.push_back(E_GIN);
        step(2, 1, 0, 4'd2, 0, 0, E_GIN);
        step(1, 0, 0, 4'd3, 1, 0, E_IDLE);
        step(6, 0, 0, 4'd3, 0, 0, E_IDLE);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain remaining=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
